// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline stall/flush scheduler.
// FSM state codes, control bundle layout and counter width default.
package pipeline_ctrl_pkg;

    localparam int CNT_W_DEF = 32;

    localparam logic [2:0] S_INIT     = 3'd0;
    localparam logic [2:0] S_RUN      = 3'd1;
    localparam logic [2:0] S_STEP     = 3'd2;
    localparam logic [2:0] S_MEM_WAIT = 3'd3;
    localparam logic [2:0] S_HALT     = 3'd4;

    typedef struct packed {
        logic pc_we;
        logic ifid_we;
        logic pipe_en;
        logic flush_IF;
        logic flush_ID;
    } ctrl_t;

    // Order: {pc_we, ifid_we, pipe_en, flush_IF, flush_ID}
    localparam ctrl_t C_IDLE   = 5'b00000;
    localparam ctrl_t C_INIT   = 5'b00011;
    localparam ctrl_t C_GO     = 5'b11100;
    localparam ctrl_t C_FLUSH  = 5'b11111;
    localparam ctrl_t C_BUBBLE = 5'b00101;

endpackage

// File: rtl/pipeline_ctrl_if.sv
// Handshake/control bundle between the scheduler and the pipeline.
// The slave side is the scheduler itself.
interface pipeline_ctrl_if
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) ();

    logic             run;
    logic             step;
    logic             load_use_hazard;
    logic             mispredict;
    logic             dmem_req;
    logic             dmem_ready;
    logic             pc_we;
    logic             ifid_we;
    logic             flush_IF;
    logic             flush_ID;
    logic             pipe_en;
    logic             halted;
    logic             mem_fault;
    logic [CNT_W-1:0] cycle_cnt;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    modport master (
        output run, step, load_use_hazard, mispredict,
        output dmem_req, dmem_ready,
        input  pc_we, ifid_we, flush_IF, flush_ID, pipe_en,
        input  halted, mem_fault,
        input  cycle_cnt, stall_cnt, flush_cnt
    );

    modport slave (
        input  run, step, load_use_hazard, mispredict,
        input  dmem_req, dmem_ready,
        output pc_we, ifid_we, flush_IF, flush_ID, pipe_en,
        output halted, mem_fault,
        output cycle_cnt, stall_cnt, flush_cnt
    );

endinterface

// File: rtl/pipeline_ctrl_perf_counter.sv
// Wrapping performance counter with increment enable.
module perf_counter
    import pipeline_ctrl_pkg::*;
#(
    parameter int CNT_W = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (inc) begin
            cnt <= cnt + CNT_W'(1);
        end
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central stall/flush scheduler for the 5-stage RV32 pipeline.
// Arbitrates memory wait, mispredict, load-use and debug run/step.
module pipeline_ctrl
    import pipeline_ctrl_pkg::*;
#(
    parameter bit START_RUN   = 1'b1,
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = CNT_W_DEF
) (
    input logic            clk,
    input logic            rst,
    pipeline_ctrl_if.slave bus
);

    localparam int            WW   = $clog2(MEM_TIMEOUT);
    localparam logic [WW-1:0] WMAX = WW'(MEM_TIMEOUT - 2);

    logic [2:0]    state;
    logic [2:0]    nxt;
    logic [WW-1:0] wcnt;
    logic          from_run;
    logic          armed;
    logic          fault;
    logic          halted_q;
    logic          fault_set;
    logic          mem_stall;
    logic          cyc_inc;
    logic          stall_inc;
    logic          flush_inc;
    ctrl_t         ctrl;

    assign mem_stall = bus.dmem_req & ~bus.dmem_ready;

    always_comb begin
        ctrl      = C_IDLE;
        nxt       = state;
        cyc_inc   = 1'b0;
        stall_inc = 1'b0;
        flush_inc = 1'b0;
        fault_set = 1'b0;
        unique case (state)
            S_INIT: begin
                ctrl = C_INIT;
                nxt  = START_RUN ? S_RUN : S_HALT;
            end
            S_RUN, S_STEP: begin
                if (mem_stall) begin
                    stall_inc = 1'b1;
                    nxt       = S_MEM_WAIT;
                end else begin
                    cyc_inc = 1'b1;
                    if (bus.mispredict) begin
                        ctrl      = C_FLUSH;
                        flush_inc = 1'b1;
                    end else if (bus.load_use_hazard) begin
                        ctrl      = C_BUBBLE;
                        stall_inc = 1'b1;
                    end else begin
                        ctrl = C_GO;
                    end
                    nxt = (state == S_RUN && bus.run) ? S_RUN : S_HALT;
                end
            end
            S_MEM_WAIT: begin
                stall_inc = 1'b1;
                if (bus.dmem_ready) begin
                    nxt = (from_run && bus.run) ? S_RUN : S_HALT;
                end else if (wcnt == WMAX) begin
                    fault_set = 1'b1;
                    nxt       = S_HALT;
                end
            end
            S_HALT: begin
                if (bus.step && armed) begin
                    nxt = S_STEP;
                end else if (bus.run && !fault) begin
                    nxt = S_RUN;
                end
            end
            default: nxt = S_INIT;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= S_INIT;
            wcnt     <= '0;
            from_run <= 1'b0;
            armed    <= 1'b1;
            fault    <= 1'b0;
            halted_q <= 1'b0;
        end else begin
            state    <= nxt;
            halted_q <= (nxt == S_HALT);
            if (fault_set) begin
                fault <= 1'b1;
            end
            if (state != S_MEM_WAIT) begin
                from_run <= (state == S_RUN);
            end
            if (state == S_MEM_WAIT && nxt == S_MEM_WAIT) begin
                wcnt <= wcnt + WW'(1);
            end else begin
                wcnt <= '0;
            end
            // A step is re-armed only by a low step level seen while halted
            if (nxt == S_STEP) begin
                armed <= 1'b0;
            end else if (state == S_HALT && !bus.step) begin
                armed <= 1'b1;
            end
        end
    end

    assign bus.pc_we     = ctrl.pc_we;
    assign bus.ifid_we   = ctrl.ifid_we;
    assign bus.pipe_en   = ctrl.pipe_en;
    assign bus.flush_IF  = ctrl.flush_IF;
    assign bus.flush_ID  = ctrl.flush_ID;
    assign bus.halted    = halted_q;
    assign bus.mem_fault = fault;

    perf_counter #(.CNT_W(CNT_W)) u_cycle (
        .clk (clk),
        .rst (rst),
        .inc (cyc_inc),
        .cnt (bus.cycle_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_stall (
        .clk (clk),
        .rst (rst),
        .inc (stall_inc),
        .cnt (bus.stall_cnt)
    );

    perf_counter #(.CNT_W(CNT_W)) u_flush (
        .clk (clk),
        .rst (rst),
        .inc (flush_inc),
        .cnt (bus.flush_cnt)
    );

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage RV32 pipeline; sole driver of every PC/IF-ID write enable, ID/EX bubble and global pipe enable.
- Arbitrates four sources: load-use hazard (from ID), branch/jalr mispredict (from EX), multi-cycle data-memory wait, and debug run/step/halt control.
- Also holds run state, a memory-wait timeout and performance counters for the debug bus.

Parameters:
- START_RUN, 1, state entered after the post-reset flush cycle (1 = RUN, 0 = HALT)
- MEM_TIMEOUT, 16, maximum consecutive memory-wait cycles before fault; >= 2
- CNT_W, 32, width of performance counters

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-high reset
- run  in  1  level; 1 = free-run, 0 = halt request
- step  in  1  single-cycle pulse; advances one pipeline cycle while halted
- load_use_hazard  in  1  from ID stage
- mispredict  in  1  EX-stage redirect (wrong prediction or jalr)
- dmem_req  in  1  MEM stage has a load/store in flight
- dmem_ready  in  1  memory completes this cycle
- pc_we  out  1  PC register write enable
- ifid_we  out  1  IF/ID register write enable
- flush_IF  out  1  zero IF/ID contents
- flush_ID  out  1  bubble into ID/EX
- pipe_en  out  1  enable for ID/EX, EX/MEM, MEM/WB
- halted  out  1  state == HALT
- mem_fault  out  1  sticky timeout flag
- cycle_cnt  out  CNT_W  advancing cycles
- stall_cnt  out  CNT_W  load-use bubbles plus memory-wait cycles
- flush_cnt  out  CNT_W  mispredict flushes

Behaviour:
- FSM states: INIT, RUN, STEP, MEM_WAIT, HALT. While rst is high the state is INIT and all counters, mem_fault and the wait counter are 0.
- INIT: flush_IF = flush_ID = 1, pc_we = ifid_we = pipe_en = 0. Held for exactly one cycle after rst deasserts, then goes to RUN if START_RUN else HALT.
- HALT: all enables 0, no flushes, halted = 1. step = 1 -> STEP. Otherwise run = 1 and mem_fault = 0 -> RUN.
- RUN/STEP "advance cycle" decode, in priority order:
  1. dmem_req & ~dmem_ready: all enables 0, no flush, next state MEM_WAIT, stall_cnt +1.
  2. mispredict: pc_we = ifid_we = pipe_en = 1, flush_IF = flush_ID = 1, flush_cnt +1. Mispredict overrides load-use, since the IF instruction is on the wrong path.
  3. load_use_hazard: pc_we = ifid_we = 0, pipe_en = 1, flush_ID = 1, stall_cnt +1.
  4. Otherwise all enables 1, no flushes.
  - cycle_cnt +1 on every RUN/STEP cycle not in case 1.
- RUN exit: run = 0 -> HALT at the next edge, unless case 1 applies (MEM_WAIT takes precedence).
- STEP: exactly one advance cycle, then HALT. If case 1 applies, go to MEM_WAIT and return to HALT afterwards. A held step level does not free-run; a new step needs step low for at least one HALT cycle.
- MEM_WAIT: all enables 0, stall_cnt +1 per cycle, wait counter +1.
  - On dmem_ready the enables are still 0 this cycle. Next state is RUN if entered from RUN with run = 1, else HALT. The memory result is latched by MEM on the ready cycle; the pipe advances on the following cycle.
  - If the wait counter reaches MEM_TIMEOUT-1 with ready still low: mem_fault <= 1, go to HALT. mem_fault clears only on rst, and run is ignored while it is set.
- Entry origin is held in one flag bit. The wait counter width is clog2(MEM_TIMEOUT) and it clears on leaving MEM_WAIT.
- Counters wrap modulo 2^CNT_W.
- All outputs are combinational from state and inputs, except halted, mem_fault and the counters, which are registered.
- rst mid-operation (any state): immediate return to INIT values, counters cleared.

Decomposition:
- Shared package holds: FSM state encoding (3-bit localparams), the enable/flush bundle bit ordering, and the CNT_W default.
- One sub-module is natural: perf_counter (CNT_W, async rst, inc enable), instantiated three times.

Test Plan:
- Reset with START_RUN = 1: release rst -> one cycle with flush_IF = flush_ID = 1 and enables 0, then pc_we = ifid_we = pipe_en = 1; cycle_cnt = 5 after 5 further cycles.
- Load-use and mispredict asserted together in RUN -> flush_IF = flush_ID = 1, pc_we = 1, flush_cnt = 1, stall_cnt = 0. Load-use alone -> pc_we = ifid_we = 0, flush_ID = 1, stall_cnt = 1.
- dmem_req = 1, ready after 3 cycles -> enables 0 for 4 cycles (entry plus 3 MEM_WAIT cycles), stall_cnt = 4, RUN resumes with enables 1.
- dmem_req held, ready never asserted, MEM_TIMEOUT = 16 -> mem_fault = 1 and halted = 1 after entry plus 15 wait cycles; run = 1 then has no effect until rst.
- run = 0, then three step pulses separated by idle cycles -> exactly three cycles with pc_we = 1, cycle_cnt +3, halted = 1 between steps. A step held high for 4 cycles -> only one advance.
- rst asserted during MEM_WAIT -> outputs take INIT values asynchronously, counters read 0, mem_fault = 0.
